muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Parametrised iterative multiply/divide unit with its own HI/LO register pair.
//  Replaces the single-cycle combinational mult/div paths of the execute stage.
//  Radix-2: one bit per cycle, with a busy/done handshake so the pipeline stalls on HI/LO hazards.
//  Also services MTHI/MTLO writes and supports a flush cancel from exception logic.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each; product/quotient+rem = 2*WIDTH
// PORTS
//  clk_cpu  in   1      CPU clock, all state on rising edge
//  reset    in   1      synchronous, active-high
//  start    in   1      request; accepted only when busy=0
//  op       in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6,7 reserved
//  rs       in   WIDTH  operand A (dividend / multiplicand / MTHI-MTLO data)
//  rt       in   WIDTH  operand B (divisor / multiplier)
//  cancel   in   1      flush in-flight op; HI/LO left unchanged
//  busy     out  1      iterative op in progress
//  done     out  1      one-cycle pulse; HI/LO hold the new result in this cycle
//  dbz      out  1      divide-by-zero flag, valid with done, else 0
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset: hi=0, lo=0, busy=0, done=0, dbz=0, state=IDLE. Reset mid-op aborts and clears all.
//  FSM: IDLE -> CALC (WIDTH cycles, bit counter WIDTH-1..0) -> FIX (1 cycle) -> IDLE.
//   - busy = (state != IDLE).
//  Accept: start=1 and busy=0 at an edge; rs/rt/op are latched and need not be held.
//   - Signed ops latch |rs|, |rt| plus result signs.
//   - start while busy=1 is ignored and not queued.
//  Timing (start in cycle 0): busy=1 in cycles 1..WIDTH+1.
//   - In cycle WIDTH+2: done=1, busy=0, hi/lo updated.
//   - A new start is accepted in that same cycle.
//  MULT/MULTU: shift-add on 2*WIDTH accumulator; {hi,lo} = full product.
//   - MULT negates the product if the operand signs differ.
//  DIV/DIVU: restoring shift-subtract; lo = quotient, hi = remainder.
//   - Signed: quotient negative iff signs differ; remainder takes dividend sign.
//   - Min-negative / -1: lo = min-negative, hi = 0; no flag.
//   - rt == 0: same latency; lo = all ones, hi = rs (original value); dbz=1 with done.
//  FIX cycle: sign correction and final HI/LO write happen at its closing edge.
//  MTHI/MTLO: single-cycle, never busy.
//   - The accepting edge writes rs to hi (MTHI) or lo (MTLO); the other register is unchanged.
//   - done=1 the following cycle.
//  Reserved op: accepted, no state change, no done.
//  cancel=1 at an edge:
//   - state -> IDLE; no done for the aborted op; hi/lo unchanged.
//   - A start in the same cycle is dropped.
//   - cancel while idle has no effect.
//  done and dbz are registered one-cycle pulses, never asserted simultaneously with busy.
// TESTING
//  WIDTH=32 MULT rs=-3 rt=7 -> done in cycle 34, hi=FFFFFFFF lo=FFFFFFEB, busy cycles 1..33.
//  DIVU rs=100 rt=7 -> lo=0000000E hi=00000002.
//   - DIV rs=-7 rt=2 -> lo=FFFFFFFD hi=FFFFFFFF.
//   - DIV rs=80000000 rt=FFFFFFFF -> lo=80000000 hi=0.
//  DIVU rs=5 rt=0 -> done with dbz=1, lo=FFFFFFFF hi=00000005; following cycle dbz=0.
//  MTHI AAAA5555 then MTLO 12345678 back-to-back -> hi=AAAA5555 lo=12345678, done each next cycle, busy never set.
//  MULTU FFFFFFFF*FFFFFFFF with cancel in cycle 10 -> no done, hi/lo keep prior values.
//   - A second start in cycle 3 is ignored.
//   - Reset asserted in cycle 5 of a DIV -> all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Request/response bundle of the iterative multiply/divide unit.
//   start  : request strobe, taken only while the unit is idle
//   op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   rs, rt : operand A (dividend / multiplicand / MTHI-MTLO data), operand B
//   cancel : flush of the in-flight operation
//   busy   : iterative operation in progress
//   done   : one-cycle pulse, HI/LO hold the new result in this cycle
//   dbz    : divide-by-zero flag, valid with done
//   hi, lo : HI/LO register pair
// master = requester (execute stage / bench), slave = the unit itself.
// ---------------------------------------------------------------------------
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs, rt, cancel,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, rs, rt, cancel,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
// Radix-2 iterative multiply/divide unit with its own HI/LO pair.
//   clk_cpu : CPU clock, all state updates on the rising edge
//   reset   : synchronous, active-high; aborts any operation and clears HI/LO
//   bus     : muldiv_if.slave (start/op/rs/rt/cancel in, busy/done/dbz/hi/lo out)
// Flow: IDLE -> CALC (WIDTH cycles, one bit per cycle) -> FIX (sign
// correction and HI/LO write at its closing edge) -> IDLE with done pulsed.
// MTHI/MTLO complete at the accepting edge and never raise busy.
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk_cpu,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = 2 * WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Two's-complement magnitude of v when treated as signed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            mag = ~v + WIDTH'(1);
        end else begin
            mag = v;
        end
    endfunction

    // Conditional negate of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic neg);
        cneg_w = neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // Conditional negate of a 2*WIDTH-bit value.
    function automatic logic [DW-1:0] cneg_d(input logic [DW-1:0] v, input logic neg);
        cneg_d = neg ? (~v + DW'(1)) : v;
    endfunction

    logic [1:0]       state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    // MULT: {partial product, multiplier}; DIV: {remainder, quotient/dividend}
    logic [DW-1:0]    acc_q,     acc_d;
    // MULT: multiplicand magnitude; DIV: divisor magnitude
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] rs_raw_q,  rs_raw_d;
    logic             is_div_q,  is_div_d;
    logic             neg_q,     neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic             done_q,    done_d;
    logic             dbz_q,     dbz_d;

    logic             accept_s;
    logic             sgn_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   diff_s;
    logic [DW-1:0]    prod_s;

    // Next-state, datapath iteration and result formatting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        rs_raw_d  = rs_raw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        // cancel wins over a same-cycle start, whatever the state
        accept_s = bus.start && (state_q == ST_IDLE) && !bus.cancel;
        sgn_s    = (bus.op == OP_MULT) || (bus.op == OP_DIV);

        // shift-add step: add multiplicand when the multiplier LSB is set
        sum_s   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        // restoring-division step: shift in next dividend bit, trial subtract
        trial_s = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
        diff_s  = trial_s - {1'b0, b_q};
        prod_s  = cneg_d(acc_q, neg_q);

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            b_d       = mag(bus.rs, sgn_s);
                            acc_d     = {{WIDTH{1'b0}}, mag(bus.rt, sgn_s)};
                            is_div_d  = 1'b0;
                            neg_d     = sgn_s && (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
                            neg_rem_d = 1'b0;
                            cnt_d     = CW'(WIDTH - 1);
                            state_d   = ST_CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            b_d       = mag(bus.rt, sgn_s);
                            acc_d     = {{WIDTH{1'b0}}, mag(bus.rs, sgn_s)};
                            rs_raw_d  = bus.rs;
                            is_div_d  = 1'b1;
                            neg_d     = sgn_s && (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
                            neg_rem_d = sgn_s && bus.rs[WIDTH-1];
                            cnt_d     = CW'(WIDTH - 1);
                            state_d   = ST_CALC;
                        end
                        OP_MTHI: begin
                            hi_d   = bus.rs;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.rs;
                            done_d = 1'b1;
                        end
                        default: begin
                            // reserved op: swallowed without effect
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!diff_s[WIDTH]) begin
                            acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {sum_s, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CW'(0)) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (bus.cancel) begin
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    if (is_div_q && (b_q == {WIDTH{1'b0}})) begin
                        // divide by zero: fixed pattern, original dividend in HI
                        lo_d  = {WIDTH{1'b1}};
                        hi_d  = rs_raw_q;
                        dbz_d = 1'b1;
                    end else if (is_div_q) begin
                        lo_d = cneg_w(acc_q[WIDTH-1:0], neg_q);
                        hi_d = cneg_w(acc_q[DW-1:WIDTH], neg_rem_q);
                    end else begin
                        hi_d = prod_s[DW-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CW'(0);
            acc_q     <= {DW{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            rs_raw_q  <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            rs_raw_q  <= rs_raw_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
    localparam int W = 32;

    logic clk_cpu = 1'b0;
    logic reset;
    always #5 clk_cpu = ~clk_cpu;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_seq #(.WIDTH(W)) dut (.clk_cpu(clk_cpu), .reset(reset), .bus(bus));

    int tests_run    = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_hi, exp_lo;

    task automatic tick;
        @(posedge clk_cpu);
        #1;
    endtask

    // Reference: results straight from integer arithmetic.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        longint sa, sb, q, r;
        logic [63:0] p;
        z  = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = 32'h0;
        l  = 32'h0;
        case (o)
            3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'h0) begin
                    z = 1'b1; l = 32'hFFFF_FFFF; h = a;
                end else if (o == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    l = q[31:0]; h = r[31:0];
                end else begin
                    l = a / b; h = a % b;
                end
            end
            default: begin h = 32'h0; l = 32'h0; end
        endcase
    endfunction

    // Issue one iterative op; returns in the done cycle (or after the bound).
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int dcyc, output bit bsy_ok);
        bus.start = 1'b1; bus.op = o; bus.rs = a; bus.rt = b;
        tick;
        bus.start = 1'b0; bus.rs = $urandom; bus.rt = $urandom;
        dcyc = -1; bsy_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin
                dcyc = c;
                if (bus.busy) bsy_ok = 1'b0;
                break;
            end
            if (!bus.busy) bsy_ok = 1'b0;
            tick;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        tests_run++; if (bus.hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
        tests_run++; if (bus.lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
        tests_run++; if ({bus.busy, bus.done, bus.dbz} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.dbz}); end
        reset = 1'b0;
        exp_hi = 32'h0; exp_lo = 32'h0;
        tick;
    endtask

    task automatic test_directed;
        logic [2:0]   ops [5] = '{3'd0, 3'd3, 3'd2, 3'd2, 3'd3};
        logic [W-1:0] as  [5] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
        logic [W-1:0] bs  [5] = '{32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [W-1:0] his [5] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'h0, 32'd5};
        logic [W-1:0] los [5] = '{32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
        logic         zs  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int dc; bit bok;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], dc, bok);
            tests_run++; if (dc !== W + 2) begin tests_failed++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, dc, W + 2); end
            tests_run++; if (!bok) begin tests_failed++; $display("FAIL dir_busy[%0d]: got bad busy window expected busy in cycles 1..%0d", i, W + 1); end
            tests_run++; if (bus.hi !== his[i] || bus.lo !== los[i]) begin tests_failed++; $display("FAIL dir_hilo[%0d]: got %h_%h expected %h_%h", i, bus.hi, bus.lo, his[i], los[i]); end
            tests_run++; if (bus.dbz !== zs[i]) begin tests_failed++; $display("FAIL dir_dbz[%0d]: got %b expected %b", i, bus.dbz, zs[i]); end
            exp_hi = his[i]; exp_lo = los[i];
        end
        tick;
        tests_run++; if (bus.dbz !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL dbz_pulse: got dbz=%b done=%b expected 0 0", bus.dbz, bus.done); end
    endtask

    // Random ops issued back-to-back: each new start lands in the previous done cycle.
    task automatic test_back_to_back_random;
        logic [2:0] o; logic [W-1:0] a, b, eh, el; logic ez;
        int dc; bit bok;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            model(o, a, b, eh, el, ez);
            do_op(o, a, b, dc, bok);
            tests_run++; if (dc !== W + 2 || !bok) begin tests_failed++; $display("FAIL rand_timing[%0d]: got done cycle %0d busy_ok %b expected %0d 1", i, dc, bok, W + 2); end
            tests_run++; if (bus.hi !== eh || bus.lo !== el || bus.dbz !== ez) begin tests_failed++; $display("FAIL rand_result[%0d] op%0d %h,%h: got %h_%h dbz%b expected %h_%h dbz%b", i, o, a, b, bus.hi, bus.lo, bus.dbz, eh, el, ez); end
            exp_hi = eh; exp_lo = el;
        end
    endtask

    task automatic test_mthi_mtlo;
        bus.start = 1'b1; bus.op = 3'd4; bus.rs = 32'hAAAA_5555;
        tick;
        tests_run++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.hi !== 32'hAAAA_5555 || bus.lo !== exp_lo) begin tests_failed++; $display("FAIL mthi: got done%b busy%b %h_%h expected 1 0 aaaa5555_%h", bus.done, bus.busy, bus.hi, bus.lo, exp_lo); end
        bus.op = 3'd5; bus.rs = 32'h1234_5678;
        tick;
        bus.start = 1'b0;
        tests_run++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.hi !== 32'hAAAA_5555 || bus.lo !== 32'h1234_5678) begin tests_failed++; $display("FAIL mtlo: got done%b busy%b %h_%h expected 1 0 aaaa5555_12345678", bus.done, bus.busy, bus.hi, bus.lo); end
        tick;
        tests_run++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL mt_after: got done%b busy%b expected 0 0", bus.done, bus.busy); end
        exp_hi = 32'hAAAA_5555; exp_lo = 32'h1234_5678;
    endtask

    task automatic test_reserved;
        bus.start = 1'b1; bus.op = 3'd6; bus.rs = 32'hDEAD_BEEF;
        tick;
        bus.start = 1'b0;
        tests_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL reserved_flags: got busy%b done%b expected 0 0", bus.busy, bus.done); end
        tick;
        tests_run++; if (bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin tests_failed++; $display("FAIL reserved_state: got done%b %h_%h expected 0 %h_%h", bus.done, bus.hi, bus.lo, exp_hi, exp_lo); end
    endtask

    task automatic test_ignored_start;
        int dones = 0; int dcyc = -1;
        bus.start = 1'b1; bus.op = 3'd1; bus.rs = 32'd3; bus.rt = 32'd5;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 3) begin bus.start = 1'b1; bus.op = 3'd3; bus.rs = 32'd100; bus.rt = 32'd7; end
            else bus.start = 1'b0;
            if (bus.done) begin dones++; if (dcyc < 0) dcyc = c; end
            if (c == W + 2) begin
                tests_run++; if (bus.hi !== 32'h0 || bus.lo !== 32'd15) begin tests_failed++; $display("FAIL ignore_result: got %h_%h expected 00000000_0000000f", bus.hi, bus.lo); end
            end
            tick;
        end
        tests_run++; if (dones !== 1 || dcyc !== W + 2) begin tests_failed++; $display("FAIL ignore_done: got %0d dones first at %0d expected 1 at %0d", dones, dcyc, W + 2); end
        exp_hi = 32'h0; exp_lo = 32'd15;
    endtask

    task automatic test_cancel;
        int dones = 0;
        bus.start = 1'b1; bus.op = 3'd1; bus.rs = 32'hFFFF_FFFF; bus.rt = 32'hFFFF_FFFF;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            bus.cancel = (c == 10);
            if (bus.done) dones++;
            if (c == 11) begin
                tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL cancel_busy: got %b expected 0", bus.busy); end
            end
            tick;
        end
        bus.cancel = 1'b0;
        tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL cancel_done: got %0d dones expected 0", dones); end
        tests_run++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin tests_failed++; $display("FAIL cancel_hilo: got %h_%h expected %h_%h", bus.hi, bus.lo, exp_hi, exp_lo); end
    endtask

    task automatic test_reset_mid_op;
        bus.start = 1'b1; bus.op = 3'd2; bus.rs = 32'd1000; bus.rt = 32'd3;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c < 5; c++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tests_run++; if ({bus.hi, bus.lo} !== 64'h0 || {bus.busy, bus.done, bus.dbz} !== 3'b000) begin tests_failed++; $display("FAIL reset_mid: got %h_%h flags %b expected zeros", bus.hi, bus.lo, {bus.busy, bus.done, bus.dbz}); end
        for (int c = 0; c < 40; c++) begin
            if (bus.done) begin
                tests_run++; tests_failed++; $display("FAIL reset_mid_done: got done after reset expected none");
            end
            tick;
        end
        exp_hi = 32'h0; exp_lo = 32'h0;
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.op = 3'd0; bus.rs = 32'h0; bus.rt = 32'h0; bus.cancel = 1'b0;
        test_reset;
        test_directed;
        test_back_to_back_random;
        test_mthi_mtlo;
        test_reserved;
        test_ignored_start;
        test_cancel;
        test_reset_mid_op;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
